// File: rtl/axis_frame_length_adjust_arb_pkg.sv
// rtl/axis_frame_length_adjust_arb_pkg.sv - shared types and widths for the frame arbiter
package axis_frame_length_adjust_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int LEN_W = 16;
  localparam int CNT_W = 32;

endpackage

// File: rtl/axis_frame_length_adjust_arb_if.sv
// rtl/axis_frame_length_adjust_arb_if.sv - AXI-stream bundle, COUNT lanes packed side by side
interface axis_frame_length_adjust_arb_if #(
  parameter int COUNT      = 1,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);

  logic [COUNT*DATA_WIDTH-1:0] tdata;
  logic [COUNT*KEEP_WIDTH-1:0] tkeep;
  logic [COUNT-1:0]            tvalid;
  logic [COUNT-1:0]            tready;
  logic [COUNT-1:0]            tlast;
  logic [COUNT*ID_WIDTH-1:0]   tid;
  logic [COUNT*DEST_WIDTH-1:0] tdest;
  logic [COUNT*USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axis_arb_rr_select.sv
// rtl/axis_arb_rr_select.sv - combinational round-robin pick: first request at or above ptr, wrapping
module axis_arb_rr_select #(
  parameter int S_COUNT = 4
) (
  input  logic [S_COUNT-1:0]         req,
  input  logic [$clog2(S_COUNT)-1:0] ptr,
  output logic [$clog2(S_COUNT)-1:0] idx,
  output logic                       found
);

  localparam int PW = $clog2(S_COUNT);

  // Lowest request overall covers the wrap; the second pass overrides it with
  // the lowest request at or above ptr when one exists.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int j = S_COUNT - 1; j >= 0; j--) begin
      if (req[j]) begin
        idx   = PW'(j);
        found = 1'b1;
      end
    end
    for (int j = S_COUNT - 1; j >= 0; j--) begin
      if (req[j] && (PW'(j) >= ptr)) begin
        idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/axis_frame_length_adjust_arb.sv
// rtl/axis_frame_length_adjust_arb.sv - frame-granular round-robin mux feeding one length adjust FIFO
module axis_frame_length_adjust_arb
  import axis_frame_length_adjust_arb_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  axis_frame_length_adjust_arb_if.slave  s_axis,
  axis_frame_length_adjust_arb_if.master m_axis,
  input  logic [S_COUNT*LEN_W-1:0]     s_length_min,
  input  logic [S_COUNT*LEN_W-1:0]     s_length_max,
  input  logic [S_COUNT-1:0]           enable,
  output logic [LEN_W-1:0]             length_min,
  output logic [LEN_W-1:0]             length_max,
  output logic [$clog2(S_COUNT)-1:0]   grant,
  output logic                         grant_valid,
  output logic [CNT_W-1:0]             frame_count
);

  localparam int GW = $clog2(S_COUNT);
  localparam logic [GW-1:0] LAST_IDX = GW'(S_COUNT - 1);

  state_t            state, state_nxt;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     sel_idx;
  logic              sel_found;
  logic [S_COUNT-1:0] req;
  logic              last_fire;

  assign req = s_axis.tvalid & enable;

  axis_arb_rr_select #(.S_COUNT(S_COUNT)) u_select (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (sel_idx),
    .found (sel_found)
  );

  assign grant_valid = (state == ACTIVE);
  assign last_fire   = (state == ACTIVE) && s_axis.tvalid[grant] && s_axis.tlast[grant]
                       && m_axis.tready;

  // Data path is a pure mux; only tvalid/tready are gated by the FSM.
  always_comb begin
    m_axis.tdata  = s_axis.tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    m_axis.tkeep  = s_axis.tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
    m_axis.tlast  = s_axis.tlast[grant];
    m_axis.tid    = s_axis.tid[int'(grant)*ID_WIDTH +: ID_WIDTH];
    m_axis.tdest  = s_axis.tdest[int'(grant)*DEST_WIDTH +: DEST_WIDTH];
    m_axis.tuser  = s_axis.tuser[int'(grant)*USER_WIDTH +: USER_WIDTH];
    m_axis.tvalid = (state == ACTIVE) && s_axis.tvalid[grant];
    s_axis.tready = '0;
    if (state == ACTIVE) begin
      s_axis.tready[grant] = m_axis.tready;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = ACTIVE;
      ACTIVE:  if (last_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      length_min  <= '0;
      length_max  <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      // Length pair is captured only at grant so it stays fixed for the whole frame.
      if ((state == IDLE) && sel_found) begin
        grant      <= sel_idx;
        length_min <= s_length_min[int'(sel_idx)*LEN_W +: LEN_W];
        length_max <= s_length_max[int'(sel_idx)*LEN_W +: LEN_W];
      end
      if (last_fire) begin
        rr_ptr      <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_length_adjust_arb.sv
// tb/tb_axis_frame_length_adjust_arb.sv - scoreboard bench for the frame length adjust arbiter
module tb_axis_frame_length_adjust_arb;

  localparam int S = 4;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [1:0]  g;
    logic [15:0] lmin;
    logic [15:0] lmax;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [S*16-1:0] s_length_min, s_length_max;
  logic [S-1:0]    enable;
  logic [15:0]     length_min, length_max;
  logic [1:0]      grant;
  logic            grant_valid;
  logic [31:0]     frame_count;

  axis_frame_length_adjust_arb_if #(.COUNT(S)) s_axis ();
  axis_frame_length_adjust_arb_if #(.COUNT(1)) m_axis ();

  axis_frame_length_adjust_arb #(.S_COUNT(S), .DATA_WIDTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis       (s_axis),
    .m_axis       (m_axis),
    .s_length_min (s_length_min),
    .s_length_max (s_length_max),
    .enable       (enable),
    .length_min   (length_min),
    .length_max   (length_max),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .frame_count  (frame_count)
  );

  beat_t srcq[S][$];
  exp_t  expq[$];
  int    total = 0;
  int    bad = 0;
  int    beats_seen = 0;
  int    cyc = 0;
  int    last_cyc = 0;
  bit    gap_chk = 0;
  bit    have_last = 0;
  bit    mon_first = 1;
  bit    bp_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] mkd(input int src, input int tag, input int b);
    return 64'hA5A5_0000_0000_0000 | (64'(src) << 24) | (64'(tag) << 16) | 64'(b);
  endfunction

  task automatic set_len(input int src, input logic [15:0] lmin, input logic [15:0] lmax);
    s_length_min[src*16 +: 16] = lmin;
    s_length_max[src*16 +: 16] = lmax;
  endtask

  task automatic load_frame(input int src, input int tag, input int n);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      bt.d = mkd(src, tag, b);
      bt.l = (b == n - 1);
      srcq[src].push_back(bt);
    end
  endtask

  task automatic expect_frame(input int src, input int tag, input int n,
                              input logic [15:0] lmin, input logic [15:0] lmax);
    exp_t e;
    for (int b = 0; b < n; b++) begin
      e.d = mkd(src, tag, b);
      e.l = (b == n - 1);
      e.g = 2'(src);
      e.lmin = lmin;
      e.lmax = lmax;
      expq.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout actual=%0d beats_left required=0", expq.size());
      expq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (beats_seen < target && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    total++;
    if (beats_seen < target) begin
      bad++;
      $display("FAIL wait_beats_timeout actual=%0d required=%0d", beats_seen, target);
    end
  endtask

  task automatic clear_queues();
    expq.delete();
    for (int i = 0; i < S; i++) srcq[i].delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_queues();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Source models: present queue heads, retire a beat after its handshake.
  initial begin
    logic [S-1:0] fire;
    s_axis.tvalid = '0;
    s_axis.tlast  = '0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tid    = '0;
    s_axis.tdest  = '0;
    s_axis.tuser  = '0;
    m_axis.tready = 1'b1;
    forever begin
      @(negedge clk);
      fire = s_axis.tvalid & s_axis.tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < S; i++) begin
        if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          s_axis.tvalid[i]          = 1'b1;
          s_axis.tdata[i*64 +: 64]  = srcq[i][0].d;
          s_axis.tlast[i]           = srcq[i][0].l;
        end else begin
          s_axis.tvalid[i]          = 1'b0;
          s_axis.tdata[i*64 +: 64]  = '0;
          s_axis.tlast[i]           = 1'b0;
        end
        s_axis.tkeep[i*8 +: 8] = 8'hFF;
        s_axis.tid[i*8 +: 8]   = 8'(i);
        s_axis.tdest[i*8 +: 8] = 8'(16 + i);
        s_axis.tuser[i]        = 1'b0;
      end
      m_axis.tready = bp_en ? ~m_axis.tready : 1'b1;
    end
  end

  // Monitor: every accepted output beat is checked against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_axis.tvalid[0] && m_axis.tready[0]) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat actual=%0h required=none", m_axis.tdata);
      end else begin
        e = expq.pop_front();
        chk("tdata", m_axis.tdata, e.d);
        chk("tlast", m_axis.tlast, e.l);
        chk("grant", grant, e.g);
        chk("tid", m_axis.tid, 64'(e.g));
        chk("tdest", m_axis.tdest, 64'(e.g) + 16);
        chk("tkeep", m_axis.tkeep, 8'hFF);
        chk("length_min", length_min, e.lmin);
        chk("length_max", length_max, e.lmax);
        chk("grant_valid_beat", grant_valid, 1'b1);
        if (gap_chk && have_last && mon_first) chk("frame_gap", cyc - last_cyc, 2);
        mon_first = e.l;
        if (e.l) begin
          have_last = 1;
          last_cyc  = cyc;
        end
        beats_seen++;
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0;
    enable = 4'hF;
    s_length_min = '0;
    s_length_max = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset / idle
    repeat (10) begin
      @(negedge clk);
      chk("idle_grant_valid", grant_valid, 1'b0);
      chk("idle_m_tvalid", m_axis.tvalid, 1'b0);
      chk("idle_s_tready", s_axis.tready, 4'h0);
    end
    chk("rst_frame_count", frame_count, 0);
    chk("rst_length_min", length_min, 0);
    chk("rst_length_max", length_max, 0);
    chk("rst_grant", grant, 0);

    // Single source
    set_len(2, 16'd64, 16'd1518);
    load_frame(2, 1, 3);
    expect_frame(2, 1, 3, 16'd64, 16'd1518);
    drain(50);
    chk("single_frame_count", frame_count, 1);
    chk("single_grant", grant, 2);
    chk("single_grant_valid", grant_valid, 1'b0);

    // Round robin with one idle cycle between frames
    do_reset();
    for (int i = 0; i < S; i++) set_len(i, 16'(10 + i), 16'(100 + i));
    gap_chk = 1;
    have_last = 0;
    mon_first = 1;
    load_frame(0, 2, 2);
    load_frame(1, 3, 2);
    load_frame(2, 4, 2);
    load_frame(3, 5, 2);
    load_frame(0, 6, 2);
    expect_frame(0, 2, 2, 16'd10, 16'd100);
    expect_frame(1, 3, 2, 16'd11, 16'd101);
    expect_frame(2, 4, 2, 16'd12, 16'd102);
    expect_frame(3, 5, 2, 16'd13, 16'd103);
    expect_frame(0, 6, 2, 16'd10, 16'd100);
    drain(100);
    gap_chk = 0;
    chk("rr_frame_count", frame_count, 5);

    // Enable mask and backpressure; rr_ptr is now 1
    enable = 4'b1011;
    bp_en = 1;
    load_frame(0, 7, 3);
    load_frame(1, 8, 3);
    load_frame(2, 9, 3);
    load_frame(3, 10, 3);
    expect_frame(1, 8, 3, 16'd11, 16'd101);
    expect_frame(3, 10, 3, 16'd13, 16'd103);
    expect_frame(0, 7, 3, 16'd10, 16'd100);
    drain(200);
    bp_en = 0;
    repeat (5) @(negedge clk);
    chk("masked_grant_valid", grant_valid, 1'b0);
    chk("masked_s_tready", s_axis.tready, 4'h0);
    chk("masked_frame_count", frame_count, 8);
    srcq[2].delete();
    repeat (2) @(negedge clk);
    enable = 4'hF;

    // Config change mid-frame is ignored until the next grant
    set_len(1, 16'd60, 16'd200);
    load_frame(1, 11, 4);
    load_frame(1, 12, 2);
    expect_frame(1, 11, 4, 16'd60, 16'd200);
    expect_frame(1, 12, 2, 16'd60, 16'd999);
    base = beats_seen;
    wait_beats(base + 1, 50);
    s_length_max[1*16 +: 16] = 16'd999;
    drain(100);
    chk("cfg_frame_count", frame_count, 10);

    // Mid-frame reset; length_min > length_max passes through unchanged
    set_len(3, 16'd300, 16'd9);
    load_frame(3, 13, 4);
    expect_frame(3, 13, 4, 16'd300, 16'd9);
    base = beats_seen;
    wait_beats(base + 2, 50);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_m_tvalid", m_axis.tvalid, 1'b0);
    chk("rst_mid_grant_valid", grant_valid, 1'b0);
    chk("rst_mid_s_tready", s_axis.tready, 4'h0);
    chk("rst_mid_frame_count", frame_count, 0);
    clear_queues();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    load_frame(3, 14, 2);
    load_frame(1, 15, 2);
    expect_frame(1, 15, 2, 16'd60, 16'd999);
    expect_frame(3, 14, 2, 16'd300, 16'd9);
    drain(100);
    chk("post_rst_frame_count", frame_count, 2);
    chk("post_rst_grant", grant, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_length_adjust_arb.md
# axis_frame_length_adjust_arb

Frame-granular round-robin arbiter that lets up to S_COUNT AXI-stream sources share one frame length adjust FIFO. Each source carries its own length_min/length_max pair. The arbiter grants one whole frame at a time, muxes that source onto the FIFO's input, and drives the FIFO's length configuration with the winner's pair. The pair is held stable for the full frame, which lets every source get its own pad/truncate policy through a single FIFO instance.

## Interface
Parameters:
- S_COUNT, 4, number of sources (2..16)
- DATA_WIDTH, 64, tdata width
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- ID_WIDTH, 8, tid width, passed through
- DEST_WIDTH, 8, tdest width, passed through
- USER_WIDTH, 1, tuser width, passed through

Ports:
- clk  in  1  single clock domain
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  per-source data, source i at slice i
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  per-source keep
- s_axis_tvalid  in  S_COUNT  per-source valid
- s_axis_tready  out  S_COUNT  per-source ready
- s_axis_tlast  in  S_COUNT  per-source last
- s_axis_tid / s_axis_tdest / s_axis_tuser  in  S_COUNT*ID/DEST/USER_WIDTH  sideband
- s_length_min  in  S_COUNT*16  per-source minimum length, bytes
- s_length_max  in  S_COUNT*16  per-source maximum length, bytes
- enable  in  S_COUNT  per-source arbitration enable
- m_axis_tdata / tkeep / tvalid / tlast / tid / tdest / tuser  out  matching widths  to FIFO slave port
- m_axis_tready  in  1  from FIFO
- length_min  out  16  to FIFO, granted source's minimum
- length_max  out  16  to FIFO, granted source's maximum
- grant  out  $clog2(S_COUNT)  index of current/last granted source
- grant_valid  out  1  high while a frame is granted
- frame_count  out  32  frames forwarded since reset

## Operation
- Two states: IDLE and ACTIVE.
- IDLE:
  - Request vector is s_axis_tvalid & enable.
  - If it is nonzero, pick the first requesting index searching upward, wrapping, starting at rr_ptr.
  - Register grant, load length_min/length_max from that source's slices, set grant_valid, go to ACTIVE.
- ACTIVE:
  - m_axis_* is a combinational mux of source grant.
  - s_axis_tready[grant] = m_axis_tready; all other readies are 0.
  - On a handshake with m_axis_tlast=1: set rr_ptr = grant+1 mod S_COUNT, increment frame_count (wraps at 2^32), clear grant_valid, go to IDLE.
- In IDLE, m_axis_tvalid=0 and all s_axis_tready=0.
- length_min/length_max change only on the IDLE→ACTIVE transition. They are constant from a frame's first beat through its tlast.
- Deasserting enable[i] mid-frame does not abort the frame. It only excludes source i from the next arbitration.
- Deasserting s_axis_tvalid mid-frame holds the grant. Bubbles pass through as m_axis_tvalid=0.
- Changes to s_length_* of the granted source during ACTIVE are ignored until the next grant.
- Sources whose length_min > length_max are forwarded unchanged; the FIFO's own rule applies.

## Timing
- Reset values (asynchronous on rst_n low):
  - state IDLE, grant 0, grant_valid 0, rr_ptr 0
  - length_min 0, length_max 0, frame_count 0
  - m_axis_tvalid 0, all s_axis_tready 0
- Reset asserted mid-frame: the partial frame is abandoned at the arbiter. Recovery is the downstream FIFO's responsibility.
- Grant latency: request seen in IDLE at cycle N → ACTIVE and first beat can transfer in cycle N+1.
- Inter-frame gap: exactly 1 idle cycle after each tlast handshake, even with the same source requesting again.
- Data path: zero added latency (combinational mux), no skid buffer.
- Throughput: a frame of B beats under continuous valid/ready occupies B+1 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle, per the rr_ptr order.

## Structure
- Package axis_frame_length_adjust_arb_pkg holds:
  - state enum {IDLE, ACTIVE}
  - length field width constant LEN_W=16
  - frame counter width CNT_W=32
- Sub-module axis_arb_rr_select is purely combinational: request vector plus rr_ptr → grant index and a found flag. It is parameterised on S_COUNT and is reusable.
- Top level holds:
  - state register, grant, rr_ptr
  - length and counter registers
  - output muxes

## Test plan
- Reset/idle: rst_n low then high, no valid. Expect all outputs at reset values and grant_valid=0 for 10 cycles.
- Single source: source 2 with min=64, max=1518 sends a 3-beat frame, tready=1. Expect length_min=64 and length_max=1518 from the beat-1 cycle; 3 beats on m_axis with tlast on beat 3; frame_count=1; grant=2.
- Round robin: all 4 sources valid with 2-beat frames. Expect grant order 0,1,2,3,0, each frame followed by exactly 1 idle cycle.
- Enable and backpressure: enable=4'b1011 with all valid. Expect source 2 never granted. Then toggle m_axis_tready 1/0 mid-frame; expect no beats lost or duplicated and the grant held.
- Config stability: change s_length_max of the granted source mid-frame. Expect length_max unchanged until the next grant.
- Mid-frame reset: pulse rst_n low on beat 2 of 4. Expect immediate m_axis_tvalid=0 and grant_valid=0, then fresh arbitration from rr_ptr=0.
